// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending-machine controller.
//   - 3-bit state encodings (kept as plain localparams so the encoding is
//     visible on the state output port and in legacy tooling).
//   - price_lsb(): bit offset of a product's price inside the flattened
//     price table.
package vend_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ACCEPT   = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_CHANGE   = 3'd4;

  // Product idx occupies [idx*credit_w +: credit_w] of the price table.
  function automatic int price_lsb(input int idx, input int credit_w);
    return idx * credit_w;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// vend_timer: ACCEPT-state inactivity counter.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   clr_i  synchronous clear (has priority over en_i)
//   en_i   count enable
//   tc_o   terminal count: counter equals TIMEOUT_CYCLES-1
module vend_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Next count: clear, advance, or hold once terminal count is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine controller (coin credit, selection check,
// dispense handshake, change return, cancel and inactivity refund).
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   coin_valid/coin_value       coin strobe and its value
//   sel_valid/sel_id            selection strobe and product index
//   cancel                      refund request (ACCEPT only)
//   prices                      flattened per-product price table
//   stock_empty                 per-product sold-out flags
//   dispense_ack                back-end accepts the dispense
//   state, credit               current FSM state and credit
//   dispense_req/dispense_id    dispense request and product
//   change_valid/change_amount  one-cycle change strobe and amount
//   coin_reject, sel_error, insufficient  one-cycle status pulses
// All outputs are registered.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PRODUCTS     = 4,
  parameter int CREDIT_W       = 8,
  parameter int MAX_CREDIT     = 200,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coin_valid,
  input  logic [CREDIT_W-1:0]            coin_value,
  input  logic                           sel_valid,
  input  logic [$clog2(N_PRODUCTS):0]    sel_id,
  input  logic                           cancel,
  input  logic [N_PRODUCTS*CREDIT_W-1:0] prices,
  input  logic [N_PRODUCTS-1:0]          stock_empty,
  input  logic                           dispense_ack,
  output logic [2:0]                     state,
  output logic [CREDIT_W-1:0]            credit,
  output logic                           dispense_req,
  output logic [$clog2(N_PRODUCTS)-1:0]  dispense_id,
  output logic                           change_valid,
  output logic [CREDIT_W-1:0]            change_amount,
  output logic                           coin_reject,
  output logic                           sel_error,
  output logic                           insufficient
);

  localparam int                  IDX_W   = $clog2(N_PRODUCTS);
  localparam int                  SEL_W   = IDX_W + 1;
  localparam logic [SEL_W-1:0]    N_SEL   = SEL_W'(N_PRODUCTS);
  localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);

  logic [2:0]          state_q,         state_d;
  logic [CREDIT_W-1:0] credit_q,        credit_d;
  logic [SEL_W-1:0]    sel_q,           sel_d;
  logic                dispense_req_q,  dispense_req_d;
  logic [IDX_W-1:0]    dispense_id_q,   dispense_id_d;
  logic                change_valid_q,  change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                coin_reject_q,   coin_reject_d;
  logic                sel_error_q,     sel_error_d;
  logic                insufficient_q,  insufficient_d;

  logic [CREDIT_W:0]   sum_s;
  logic                coin_fits_s;
  logic [IDX_W-1:0]    idx_s;
  logic [CREDIT_W-1:0] price_s;
  logic                sel_bad_s;
  logic                tmr_tc_s;

  // One extra bit on the sum so an over-cap coin can never wrap into range.
  assign sum_s       = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits_s = (sum_s <= MAX_EXT);
  assign idx_s       = sel_q[IDX_W-1:0];
  assign price_s     = prices[price_lsb(int'(idx_s), CREDIT_W) +: CREDIT_W];
  assign sel_bad_s   = (sel_q >= N_SEL) || stock_empty[idx_s];

  vend_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i ((state_q != ST_ACCEPT) || coin_valid || sel_valid),
    .en_i  (state_q == ST_ACCEPT),
    .tc_o  (tmr_tc_s)
  );

  // FSM next state, credit datapath and registered-output next values.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_d          = sel_q;
    dispense_id_d  = dispense_id_q;
    coin_reject_d  = 1'b0;
    sel_error_d    = 1'b0;
    insufficient_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          if ((coin_value == {CREDIT_W{1'b0}}) || ({1'b0, coin_value} > MAX_EXT)) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_value;
            state_d  = ST_ACCEPT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCEPT: begin
        // Coin is credited before cancel/selection act on the same cycle.
        if (coin_valid) begin
          if (coin_fits_s) begin
            credit_d = sum_s[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          credit_d = credit_q;
        end
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (sel_valid) begin
          sel_d   = sel_id;
          state_d = ST_CHECK;
        end else if (tmr_tc_s) begin
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end

      ST_CHECK: begin
        coin_reject_d = coin_valid;
        if (sel_bad_s) begin
          sel_error_d = 1'b1;
          state_d     = ST_ACCEPT;
        end else if (credit_q < price_s) begin
          insufficient_d = 1'b1;
          state_d        = ST_ACCEPT;
        end else begin
          credit_d      = credit_q - price_s;
          dispense_id_d = idx_s;
          state_d       = ST_DISPENSE;
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (dispense_ack) begin
          state_d = (credit_q != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = {CREDIT_W{1'b0}};
        state_d       = ST_IDLE;
      end

      default: begin
        credit_d = {CREDIT_W{1'b0}};
        state_d  = ST_IDLE;
      end
    endcase

    // Outputs tied to the state being entered, so they align with it.
    dispense_req_d  = (state_d == ST_DISPENSE);
    change_valid_d  = (state_d == ST_CHANGE);
    change_amount_d = change_valid_d ? credit_d : {CREDIT_W{1'b0}};
  end

  // State, credit and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      credit_q        <= {CREDIT_W{1'b0}};
      sel_q           <= {SEL_W{1'b0}};
      dispense_req_q  <= 1'b0;
      dispense_id_q   <= {IDX_W{1'b0}};
      change_valid_q  <= 1'b0;
      change_amount_q <= {CREDIT_W{1'b0}};
      coin_reject_q   <= 1'b0;
      sel_error_q     <= 1'b0;
      insufficient_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      sel_q           <= sel_d;
      dispense_req_q  <= dispense_req_d;
      dispense_id_q   <= dispense_id_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      coin_reject_q   <= coin_reject_d;
      sel_error_q     <= sel_error_d;
      insufficient_q  <= insufficient_d;
    end
  end

  assign state         = state_q;
  assign credit        = credit_q;
  assign dispense_req  = dispense_req_q;
  assign dispense_id   = dispense_id_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign coin_reject   = coin_reject_q;
  assign sel_error     = sel_error_q;
  assign insufficient  = insufficient_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scenarios for vend_ctrl with hand-computed results.
// Configuration: 4 products priced {50,75,100,125}, 8-bit credit, cap 200,
// timeout 16 cycles.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = 8'd0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_id = 3'd0;
  logic       cancel = 1'b0;
  logic [31:0] prices = {8'd125, 8'd100, 8'd75, 8'd50};
  logic [3:0] stock_empty = 4'd0;
  logic       dispense_ack = 1'b0;

  logic [2:0] state;
  logic [7:0] credit;
  logic       dispense_req;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       sel_error;
  logic       insufficient;

  int checks = 0;
  int errors = 0;

  vend_ctrl #(
    .N_PRODUCTS(4), .CREDIT_W(8), .MAX_CREDIT(200), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .prices(prices),
    .stock_empty(stock_empty), .dispense_ack(dispense_ack), .state(state),
    .credit(credit), .dispense_req(dispense_req), .dispense_id(dispense_id),
    .change_valid(change_valid), .change_amount(change_amount),
    .coin_reject(coin_reject), .sel_error(sel_error), .insufficient(insufficient)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0; coin_value = 8'd0;
  endtask

  task automatic sel(input logic [2:0] id);
    sel_valid = 1'b1; sel_id = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic ack;
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({credit, change_amount} !== 16'd0) begin errors++; $display("FAIL reset_credit_change: got %0d/%0d want 0/0", credit, change_amount); end
    checks++; if ({dispense_req, dispense_id, change_valid, coin_reject, sel_error, insufficient} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {dispense_req, dispense_id, change_valid, coin_reject, sel_error, insufficient}); end
    @(negedge clk); rst = 1'b1;
    tick();
    // Selection and cancel are ignored in IDLE.
    sel_valid = 1'b1; sel_id = 3'd0; cancel = 1'b1;
    tick();
    sel_valid = 1'b0; cancel = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore: got state %0d chg %0d want 0 0", state, change_valid); end
  endtask

  task automatic test_exact_payment;
    coin(8'd25);
    checks++; if (credit !== 8'd25 || state !== 3'd1) begin errors++; $display("FAIL exact_coin1: got %0d st %0d want 25 st 1", credit, state); end
    coin(8'd25);
    checks++; if (credit !== 8'd50) begin errors++; $display("FAIL exact_coin2: got %0d want 50", credit); end
    sel(3'd0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL exact_check: got %0d want 2", state); end
    tick();
    checks++; if (state !== 3'd3 || dispense_req !== 1'b1 || dispense_id !== 2'd0 || credit !== 8'd0) begin
      errors++; $display("FAIL exact_dispense: got st %0d req %0d id %0d cr %0d want 3 1 0 0", state, dispense_req, dispense_id, credit); end
    tick(); tick();
    checks++; if (dispense_req !== 1'b1) begin errors++; $display("FAIL exact_req_hold: got %0d want 1", dispense_req); end
    ack();
    checks++; if (state !== 3'd0 || change_valid !== 1'b0 || dispense_req !== 1'b0) begin
      errors++; $display("FAIL exact_done: got st %0d chg %0d req %0d want 0 0 0", state, change_valid, dispense_req); end
  endtask

  task automatic test_change;
    coin(8'd100);
    coin(8'd50);
    checks++; if (credit !== 8'd150) begin errors++; $display("FAIL change_credit: got %0d want 150", credit); end
    sel(3'd1);
    tick();
    checks++; if (credit !== 8'd75 || dispense_id !== 2'd1) begin errors++; $display("FAIL change_disp: got cr %0d id %0d want 75 1", credit, dispense_id); end
    ack();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd75 || state !== 3'd4) begin
      errors++; $display("FAIL change_strobe: got v %0d amt %0d st %0d want 1 75 4", change_valid, change_amount, state); end
    tick();
    checks++; if (state !== 3'd0 || change_valid !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL change_idle: got st %0d v %0d cr %0d want 0 0 0", state, change_valid, credit); end
  endtask

  task automatic test_insufficient;
    coin(8'd50);
    sel(3'd3);
    tick();
    checks++; if (insufficient !== 1'b1 || state !== 3'd1 || credit !== 8'd50) begin
      errors++; $display("FAIL insuf_pulse: got p %0d st %0d cr %0d want 1 1 50", insufficient, state, credit); end
    tick();
    checks++; if (insufficient !== 1'b0) begin errors++; $display("FAIL insuf_one_cycle: got %0d want 0", insufficient); end
    coin(8'd100);
    sel(3'd3);
    tick();
    checks++; if (state !== 3'd3 || credit !== 8'd25 || dispense_id !== 2'd3) begin
      errors++; $display("FAIL insuf_topup: got st %0d cr %0d id %0d want 3 25 3", state, credit, dispense_id); end
    ack();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd25) begin
      errors++; $display("FAIL insuf_change: got v %0d amt %0d want 1 25", change_valid, change_amount); end
    tick();
  endtask

  task automatic test_overflow_busy;
    coin(8'd0);
    checks++; if (coin_reject !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL idle_zero_coin: got rej %0d st %0d want 1 0", coin_reject, state); end
    coin(8'd201);
    checks++; if (coin_reject !== 1'b1 || state !== 3'd0 || credit !== 8'd0) begin
      errors++; $display("FAIL idle_big_coin: got rej %0d st %0d cr %0d want 1 0 0", coin_reject, state, credit); end
    coin(8'd100);
    coin(8'd100);
    checks++; if (credit !== 8'd200 || coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_cap: got cr %0d rej %0d want 200 0", credit, coin_reject); end
    coin(8'd10);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL ovf_reject: got rej %0d cr %0d want 1 200", coin_reject, credit); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %0d want 0", coin_reject); end
    sel(3'd0);
    tick();
    coin(8'd5);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd150 || state !== 3'd3) begin
      errors++; $display("FAIL busy_reject: got rej %0d cr %0d st %0d want 1 150 3", coin_reject, credit, state); end
    ack();
    checks++; if (change_amount !== 8'd150 || change_valid !== 1'b1) begin
      errors++; $display("FAIL busy_change: got amt %0d v %0d want 150 1", change_amount, change_valid); end
    tick();
  endtask

  task automatic test_invalid_sel;
    coin(8'd100);
    stock_empty = 4'b0100;
    sel(3'd2);
    tick();
    checks++; if (sel_error !== 1'b1 || state !== 3'd1 || credit !== 8'd100) begin
      errors++; $display("FAIL sel_soldout: got err %0d st %0d cr %0d want 1 1 100", sel_error, state, credit); end
    sel(3'd4);
    tick();
    checks++; if (sel_error !== 1'b1 || state !== 3'd1 || credit !== 8'd100) begin
      errors++; $display("FAIL sel_range: got err %0d st %0d cr %0d want 1 1 100", sel_error, state, credit); end
    stock_empty = 4'd0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd100) begin
      errors++; $display("FAIL sel_cancel: got v %0d amt %0d want 1 100", change_valid, change_amount); end
    tick();
  endtask

  task automatic test_timeout_cancel_reset;
    coin(8'd50);
    repeat (15) tick();
    checks++; if (state !== 3'd1 || change_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got st %0d v %0d want 1 0", state, change_valid); end
    tick();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd50) begin
      errors++; $display("FAIL timeout_refund: got v %0d amt %0d want 1 50", change_valid, change_amount); end
    tick();
    checks++; if (state !== 3'd0 || credit !== 8'd0) begin errors++; $display("FAIL timeout_idle: got st %0d cr %0d want 0 0", state, credit); end
    coin(8'd75);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd75) begin
      errors++; $display("FAIL cancel_refund: got v %0d amt %0d want 1 75", change_valid, change_amount); end
    tick();
    coin(8'd100);
    sel(3'd0);
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rst_pre_dispense: got %0d want 3", state); end
    #3 rst = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || credit !== 8'd0 || dispense_req !== 1'b0 || dispense_id !== 2'd0 || change_valid !== 1'b0 || change_amount !== 8'd0) begin
      errors++; $display("FAIL rst_async: got st %0d cr %0d req %0d id %0d v %0d amt %0d want all 0", state, credit, dispense_req, dispense_id, change_valid, change_amount); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (state !== 3'd0 || change_valid !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL rst_release: got st %0d v %0d cr %0d want 0 0 0", state, change_valid, credit); end
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_change();
    test_insufficient();
    test_overflow_busy();
    test_invalid_sel();
    test_timeout_cancel_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending-machine controller, next generation of the four-state coin/check/dispense FSM. Key additions:
- N selectable products with per-product prices.
- Credit accumulation from multi-value coins, with an overflow cap.
- Stock and selection validation.
- A dispense request/acknowledge handshake.
- Change return, cancel, and inactivity timeout.

It sits between the coin acceptor and keypad front-end and the dispenser/change-hopper back-end.

## Interface
- N_PRODUCTS, 4, number of selectable products (≥2).
- CREDIT_W, 8, width of credit, price and coin value.
- MAX_CREDIT, 200, highest credit the machine will hold.
- TIMEOUT_CYCLES, 1024, ACCEPT inactivity limit before auto-refund (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin-insert strobe.
- coin_value  in  CREDIT_W  value of inserted coin; sampled when coin_valid=1.
- sel_valid  in  1  one-cycle selection strobe.
- sel_id  in  $clog2(N_PRODUCTS)+1  product index; sampled when sel_valid=1.
- cancel  in  1  refund request.
- prices  in  N_PRODUCTS*CREDIT_W  flattened price table; product i is at [i*CREDIT_W +: CREDIT_W]; must be static while not IDLE.
- stock_empty  in  N_PRODUCTS  per-product sold-out flags.
- dispense_ack  in  1  back-end accepts the dispense.
- state  out  3  current state encoding.
- credit  out  CREDIT_W  current credit.
- dispense_req  out  1  held high in DISPENSE until acknowledged.
- dispense_id  out  $clog2(N_PRODUCTS)  product being dispensed.
- change_valid  out  1  one-cycle change strobe.
- change_amount  out  CREDIT_W  refund value; valid with change_valid.
- coin_reject  out  1  one-cycle pulse: coin returned, not credited.
- sel_error  out  1  one-cycle pulse: invalid or sold-out selection.
- insufficient  out  1  one-cycle pulse: credit below price.

## Operation
States, with the `state` encoding: IDLE=0, ACCEPT=1, CHECK=2, DISPENSE=3, CHANGE=4.

**IDLE**
- coin_valid → credit := coin_value, go to ACCEPT.
- sel_valid and cancel are ignored.
- A coin with coin_value=0 or coin_value>MAX_CREDIT is rejected and the state stays IDLE.

**ACCEPT**
- coin_valid → credit += coin_value if the sum ≤ MAX_CREDIT.
  - Otherwise: coin_reject pulse, credit unchanged.
  - The sum is computed at CREDIT_W+1 bits, so there is no wrap-around.
- cancel → CHANGE. Priority is cancel > sel_valid; a coin in the cancel cycle is still credited.
- sel_valid → latch sel_id, go to CHECK. A coin in the same cycle is credited first.
- The inactivity counter clears on any coin_valid or sel_valid. When it reaches TIMEOUT_CYCLES-1 → CHANGE.

**CHECK** (always exactly one cycle)
- sel_id ≥ N_PRODUCTS, or stock_empty[sel_id]=1 → sel_error pulse, back to ACCEPT.
- Else, credit < price → insufficient pulse, back to ACCEPT.
- Else → credit -= price, dispense_id := sel_id, go to DISPENSE.

**DISPENSE**
- dispense_req=1 until the cycle in which dispense_ack=1.
- On that cycle: credit≠0 → CHANGE; credit=0 → IDLE.

**CHANGE** (one cycle)
- change_valid=1 and change_amount=credit; credit := 0; next state is IDLE.

**Coin rejection outside IDLE/ACCEPT:** any coin_valid in CHECK, DISPENSE or CHANGE produces a coin_reject pulse and is never credited.

**Illegal state encodings** (5–7) → IDLE with credit cleared.

## Timing
- All outputs are registered.
- Reset (async assert, release synchronous to clk): state=IDLE. All of the following are 0:
  - credit, dispense_req, dispense_id, change_valid, change_amount;
  - coin_reject, sel_error, insufficient;
  - the timeout counter.
- Coin strobe at cycle t → credit updated at t+1.
- sel_valid at t → CHECK at t+1 → dispense_req high from t+2.
- Ack at cycle a → change_valid at a+1 (when change is due), IDLE at a+2.
- Pulse outputs are high for exactly one cycle, in the cycle after the causing event.
- Reset mid-operation aborts without a refund strobe; credit is lost by design.
- dispense_ack outside DISPENSE is ignored.

## Structure
- Package vend_pkg holds:
  - state localparams (3-bit encoding);
  - a price-slice helper function.
- Sub-module vend_timer: a clear/enable counter of width $clog2(TIMEOUT_CYCLES) with a terminal-count output. It is cleared outside ACCEPT.
- Top-level vend_ctrl holds the FSM, the credit register and the datapath.

## Test plan
Configuration for all scenarios: N_PRODUCTS=4, CREDIT_W=8, MAX_CREDIT=200, TIMEOUT_CYCLES=16, prices={50,75,100,125}.

1. **Exact payment:** coins 25, 25; select 0; ack 3 cycles later → dispense_id=0, credit=0, no change_valid, back to IDLE.
2. **Payment with change:** coins 100, 50; select 1; immediate ack → change_valid with change_amount=75, then IDLE.
3. **Insufficient, then top-up:** coin 50; select 3 → insufficient pulse, state ACCEPT, credit=50. Coin 100; select 3 → dispense, change 25.
4. **Overflow and busy rejects:** coins 100, 100, then 10 → coin_reject, credit=200. A coin inserted during DISPENSE → coin_reject.
5. **Invalid selections:** stock_empty[2]=1, select 2 → sel_error. Select 4 → sel_error. Credit is unchanged in both cases.
6. **Timeout, cancel, reset:**
   - Coin 50, then 16 idle cycles → change_amount=50.
   - Coin 75, then cancel → change_amount=75.
   - Async reset asserted during DISPENSE → all outputs 0, state IDLE.
